collision_hp_tracker: RTL and testbench

Multi-bullet successor to the single-pair collision checker. Compares one player/enemy unit against NUM_BULLETS bullets in parallel using a true symmetric hitbox, and owns the unit's HP counter. After each hit it applies an invulnerability cooldown, reports which bullet hit so the bullet manager can retire it, and flags death. It sits between the bullet manager and the game-state/HUD logic, one instance per unit.

---
 rtl/collision_pkg.sv | 14 +
 rtl/hitbox_compare.sv | 28 ++
 rtl/collision_hp_tracker.sv | 148 ++++++++++++++
 tb/tb_collision_hp_tracker.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/collision_pkg.sv
// rtl/collision_pkg.sv - shared state encoding and default constants for the collision/HP tracker
package collision_pkg;

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    COOLDOWN = 2'd1,
    DEAD     = 2'd2
  } state_e;

  localparam int HIT_SIZE_DEF    = 7;
  localparam int COOL_CYCLES_DEF = 8000000;
  localparam int HP_INIT_DEF     = 3;

endpackage

// File: rtl/hitbox_compare.sv
// rtl/hitbox_compare.sv - symmetric square hitbox test of one bullet against the unit
module hitbox_compare
  import collision_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int HIT_SIZE = HIT_SIZE_DEF
) (
  input  logic [X_W-1:0] bullet_x,
  input  logic [Y_W-1:0] bullet_y,
  input  logic           bullet_valid,
  input  logic [X_W-1:0] unit_x,
  input  logic [Y_W-1:0] unit_y,
  output logic           overlap
);

  localparam logic [31:0] HIT_LIM = 32'(HIT_SIZE);

  logic [X_W-1:0] dx;
  logic [Y_W-1:0] dy;

  // Larger minus smaller so coordinates never wrap around the playfield edge.
  assign dx = (bullet_x >= unit_x) ? (bullet_x - unit_x) : (unit_x - bullet_x);
  assign dy = (bullet_y >= unit_y) ? (bullet_y - unit_y) : (unit_y - bullet_y);

  assign overlap = bullet_valid && (32'(dx) < HIT_LIM) && (32'(dy) < HIT_LIM);

endmodule

// File: rtl/collision_hp_tracker.sv
// rtl/collision_hp_tracker.sv - multi-bullet hit detection, HP counter, cooldown and death FSM
module collision_hp_tracker
  import collision_pkg::*;
#(
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int NUM_BULLETS = 8,
  parameter int IDX_W       = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1,
  parameter int HIT_SIZE    = HIT_SIZE_DEF,
  parameter int COOL_CYCLES = COOL_CYCLES_DEF,
  parameter int HP_W        = 4,
  parameter int HP_INIT     = HP_INIT_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       respawn,
  input  logic [NUM_BULLETS*X_W-1:0] bullet_x,
  input  logic [NUM_BULLETS*Y_W-1:0] bullet_y,
  input  logic [NUM_BULLETS-1:0]     bullet_valid,
  input  logic [X_W-1:0]             unit_x,
  input  logic [Y_W-1:0]             unit_y,
  output logic                       hit,
  output logic [IDX_W-1:0]           hit_idx,
  output logic [NUM_BULLETS-1:0]     bullet_kill,
  output logic                       invuln,
  output logic [HP_W-1:0]            hp,
  output logic                       dead
);

  localparam int               CNT_W     = (COOL_CYCLES > 1) ? $clog2(COOL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(COOL_CYCLES - 1);
  localparam logic [HP_W-1:0]  HP_RELOAD = HP_W'(HP_INIT);

  logic [NUM_BULLETS-1:0] overlap;
  logic                   any_hit;
  logic [IDX_W-1:0]       hit_idx_d;
  logic [NUM_BULLETS-1:0] kill_d;

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [HP_W-1:0]        hp_q;
  logic                   hit_q;
  logic [IDX_W-1:0]       hit_idx_q;
  logic [NUM_BULLETS-1:0] kill_q;
  logic                   invuln_q;
  logic                   dead_q;

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_hitbox
    hitbox_compare #(
      .X_W      (X_W),
      .Y_W      (Y_W),
      .HIT_SIZE (HIT_SIZE)
    ) u_hitbox (
      .bullet_x     (bullet_x[g*X_W +: X_W]),
      .bullet_y     (bullet_y[g*Y_W +: Y_W]),
      .bullet_valid (bullet_valid[g]),
      .unit_x       (unit_x),
      .unit_y       (unit_y),
      .overlap      (overlap[g])
    );
  end

  // Scan from the top down so the lowest colliding slot is the last one written.
  always_comb begin
    any_hit   = |overlap;
    hit_idx_d = '0;
    kill_d    = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (overlap[i]) begin
        hit_idx_d = IDX_W'(i);
        kill_d    = '0;
        kill_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARMED;
      cnt_q     <= '0;
      hp_q      <= HP_RELOAD;
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
      kill_q    <= '0;
      invuln_q  <= 1'b0;
      dead_q    <= 1'b0;
    end else begin
      hit_q  <= 1'b0;
      kill_q <= '0;
      if (enable) begin
        if (respawn) begin
          hp_q     <= HP_RELOAD;
          state_q  <= COOLDOWN;
          cnt_q    <= '0;
          invuln_q <= 1'b1;
          dead_q   <= 1'b0;
        end else begin
          case (state_q)
            ARMED: begin
              if (any_hit) begin
                hit_q     <= 1'b1;
                hit_idx_q <= hit_idx_d;
                kill_q    <= kill_d;
                hp_q      <= hp_q - HP_W'(1);
                cnt_q     <= '0;
                if (hp_q == HP_W'(1)) begin
                  state_q  <= DEAD;
                  invuln_q <= 1'b0;
                  dead_q   <= 1'b1;
                end else begin
                  state_q  <= COOLDOWN;
                  invuln_q <= 1'b1;
                  dead_q   <= 1'b0;
                end
              end
            end
            COOLDOWN: begin
              if (cnt_q == CNT_LAST) begin
                state_q  <= ARMED;
                cnt_q    <= '0;
                invuln_q <= 1'b0;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
            DEAD: begin
              hp_q <= '0;
            end
            default: begin
              state_q  <= ARMED;
              invuln_q <= 1'b0;
              dead_q   <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign hit         = hit_q;
  assign hit_idx     = hit_idx_q;
  assign bullet_kill = kill_q;
  assign invuln      = invuln_q;
  assign hp          = hp_q;
  assign dead        = dead_q;

endmodule

// File: tb/tb_collision_hp_tracker.sv
// tb/tb_collision_hp_tracker.sv - scoreboard bench for collision_hp_tracker with directed vectors
module tb_collision_hp_tracker;

  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          respawn;
  logic [NB*8-1:0] bullet_x;
  logic [NB*7-1:0] bullet_y;
  logic [NB-1:0] bullet_valid;
  logic [7:0]    unit_x;
  logic [6:0]    unit_y;
  logic          hit;
  logic [2:0]    hit_idx;
  logic [NB-1:0] bullet_kill;
  logic          invuln;
  logic [3:0]    hp;
  logic          dead;

  typedef struct {
    logic       h;
    logic [2:0] idx;
    logic [7:0] kill;
    logic       inv;
    logic [3:0] hp;
    logic       dead;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   next_id  = 0;

  always #5 clk = ~clk;

  collision_hp_tracker #(
    .X_W         (8),
    .Y_W         (7),
    .NUM_BULLETS (NB),
    .HIT_SIZE    (7),
    .COOL_CYCLES (4),
    .HP_W        (4),
    .HP_INIT     (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .respawn      (respawn),
    .bullet_x     (bullet_x),
    .bullet_y     (bullet_y),
    .bullet_valid (bullet_valid),
    .unit_x       (unit_x),
    .unit_y       (unit_y),
    .hit          (hit),
    .hit_idx      (hit_idx),
    .bullet_kill  (bullet_kill),
    .invuln       (invuln),
    .hp           (hp),
    .dead         (dead)
  );

  // Monitor: pops one expectation per clock, sampled shortly after the edge.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (hit !== e.h || hit_idx !== e.idx || bullet_kill !== e.kill ||
          invuln !== e.inv || hp !== e.hp || dead !== e.dead) begin
        n_errors++;
        $display("FAIL vec%0d: got hit=%b idx=%0d kill=%b inv=%b hp=%0d dead=%b, want hit=%b idx=%0d kill=%b inv=%b hp=%0d dead=%b",
                 e.id, hit, hit_idx, bullet_kill, invuln, hp, dead,
                 e.h, e.idx, e.kill, e.inv, e.hp, e.dead);
      end
    end
  end

  task automatic cyc(input logic r, input logic en, input logic rs,
                     input logic eh, input logic [2:0] ei, input logic [7:0] ek,
                     input logic ev, input logic [3:0] ehp, input logic ed);
    exp_t e;
    rst     = r;
    enable  = en;
    respawn = rs;
    e.h = eh; e.idx = ei; e.kill = ek; e.inv = ev; e.hp = ehp; e.dead = ed;
    e.id = next_id;
    next_id++;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic set_bullet(input int slot, input logic [7:0] x, input logic [6:0] y,
                            input logic v);
    bullet_x[slot*8 +: 8] = x;
    bullet_y[slot*7 +: 7] = y;
    bullet_valid[slot]    = v;
  endtask

  task automatic clear_bullets();
    bullet_x     = '0;
    bullet_y     = '0;
    bullet_valid = '0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; respawn = 1'b0;
    clear_bullets();
    unit_x = 8'd100; unit_y = 7'd50;

    // Boundary geometry
    cyc(1,1,0, 0,0,8'h00, 0,3,0);
    set_bullet(0, 8'd106, 7'd50, 1);
    cyc(0,1,0, 1,0,8'h01, 1,2,0);
    clear_bullets();
    cyc(1,1,0, 0,0,8'h00, 0,3,0);
    set_bullet(0, 8'd107, 7'd50, 1);
    cyc(0,1,0, 0,0,8'h00, 0,3,0);
    cyc(0,1,0, 0,0,8'h00, 0,3,0);
    set_bullet(0, 8'd94, 7'd44, 1);
    cyc(0,1,0, 1,0,8'h01, 1,2,0);
    clear_bullets();
    cyc(1,1,0, 0,0,8'h00, 0,3,0);
    unit_x = 8'd250;
    set_bullet(0, 8'd0, 7'd50, 1);
    cyc(0,1,0, 0,0,8'h00, 0,3,0);
    cyc(0,1,0, 0,0,8'h00, 0,3,0);

    // Priority: slot 1 invalid, slots 2 and 5 overlap
    clear_bullets();
    unit_x = 8'd100;
    cyc(1,1,0, 0,0,8'h00, 0,3,0);
    set_bullet(1, 8'd100, 7'd50, 0);
    set_bullet(2, 8'd103, 7'd47, 1);
    set_bullet(5, 8'd97,  7'd53, 1);
    cyc(0,1,0, 1,2,8'h04, 1,2,0);
    cyc(0,1,0, 0,2,8'h00, 1,2,0);

    // Cooldown with continuous overlap down to death
    clear_bullets();
    cyc(1,1,0, 0,0,8'h00, 0,3,0);
    set_bullet(0, 8'd100, 7'd50, 1);
    cyc(0,1,0, 1,0,8'h01, 1,2,0);
    for (int i = 0; i < 3; i++) cyc(0,1,0, 0,0,8'h00, 1,2,0);
    cyc(0,1,0, 0,0,8'h00, 0,2,0);
    cyc(0,1,0, 1,0,8'h01, 1,1,0);
    for (int i = 0; i < 3; i++) cyc(0,1,0, 0,0,8'h00, 1,1,0);
    cyc(0,1,0, 0,0,8'h00, 0,1,0);
    cyc(0,1,0, 1,0,8'h01, 0,0,1);
    for (int i = 0; i < 3; i++) cyc(0,1,0, 0,0,8'h00, 0,0,1);

    // Respawn from DEAD, then respawn racing a hit in ARMED
    clear_bullets();
    cyc(0,1,1, 0,0,8'h00, 1,3,0);
    for (int i = 0; i < 3; i++) cyc(0,1,0, 0,0,8'h00, 1,3,0);
    cyc(0,1,0, 0,0,8'h00, 0,3,0);
    set_bullet(0, 8'd100, 7'd50, 1);
    cyc(0,1,1, 0,0,8'h00, 1,3,0);
    clear_bullets();
    for (int i = 0; i < 3; i++) cyc(0,1,0, 0,0,8'h00, 1,3,0);
    cyc(0,1,0, 0,0,8'h00, 0,3,0);

    // Pause during cooldown, then paused overlap and paused respawn in ARMED
    set_bullet(0, 8'd100, 7'd50, 1);
    cyc(0,1,0, 1,0,8'h01, 1,2,0);
    clear_bullets();
    cyc(0,1,0, 0,0,8'h00, 1,2,0);
    for (int i = 0; i < 10; i++) cyc(0,0,0, 0,0,8'h00, 1,2,0);
    cyc(0,1,0, 0,0,8'h00, 1,2,0);
    cyc(0,1,0, 0,0,8'h00, 1,2,0);
    cyc(0,1,0, 0,0,8'h00, 0,2,0);
    set_bullet(0, 8'd100, 7'd50, 1);
    cyc(0,0,0, 0,0,8'h00, 0,2,0);
    cyc(0,0,0, 0,0,8'h00, 0,2,0);
    cyc(0,0,1, 0,0,8'h00, 0,2,0);
    cyc(0,1,0, 1,0,8'h01, 1,1,0);

    // Mid-cooldown reset with hp=1, reset beating respawn, then re-hit
    cyc(0,1,0, 0,0,8'h00, 1,1,0);
    cyc(1,1,1, 0,0,8'h00, 0,3,0);
    cyc(0,1,0, 1,0,8'h01, 1,2,0);

    rst = 1'b0; enable = 1'b0; respawn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
